// File: rtl/sevenseg_pkg.sv
// Shared segment patterns {a,b,c,d,e,f,g} (active-high) and digit index sizing
// for the seven-segment scan driver.
package sevenseg_pkg;

   localparam logic [6:0] SEG_0   = 7'b1111110;
   localparam logic [6:0] SEG_1   = 7'b0110000;
   localparam logic [6:0] SEG_2   = 7'b1101101;
   localparam logic [6:0] SEG_3   = 7'b1111001;
   localparam logic [6:0] SEG_4   = 7'b0110011;
   localparam logic [6:0] SEG_5   = 7'b1011011;
   localparam logic [6:0] SEG_6   = 7'b1011111;
   localparam logic [6:0] SEG_7   = 7'b1110000;
   localparam logic [6:0] SEG_8   = 7'b1111111;
   localparam logic [6:0] SEG_9   = 7'b1111011;
   localparam logic [6:0] SEG_A   = 7'b1110111;
   localparam logic [6:0] SEG_B   = 7'b0011111;
   localparam logic [6:0] SEG_C   = 7'b1001110;
   localparam logic [6:0] SEG_D   = 7'b0111101;
   localparam logic [6:0] SEG_E   = 7'b1001111;
   localparam logic [6:0] SEG_F   = 7'b1000111;
   localparam logic [6:0] SEG_OFF = 7'b0000000;

   // A single-digit display still needs a 1-bit index port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Nibble to active-high segment pattern; purely combinational, no handshake.
// With HEX_MODE=0 the nibbles 10-15 decode to all segments off.
module sevenseg_decode
   import sevenseg_pkg::*;
#(
   parameter int HEX_MODE = 0
)(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (nib)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = (HEX_MODE != 0) ? SEG_A : SEG_OFF;
         4'hB: seg = (HEX_MODE != 0) ? SEG_B : SEG_OFF;
         4'hC: seg = (HEX_MODE != 0) ? SEG_C : SEG_OFF;
         4'hD: seg = (HEX_MODE != 0) ? SEG_D : SEG_OFF;
         4'hE: seg = (HEX_MODE != 0) ? SEG_E : SEG_OFF;
         default: seg = (HEX_MODE != 0) ? SEG_F : SEG_OFF;
      endcase
   end

endmodule

// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed seven-segment driver, one digit per CLK_DIV-cycle slot.
// an/seg/dp are registered one clock behind digit_idx; no backpressure, load always accepted.
module sevenseg_scan_mux
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYCLES   = 0,
   parameter int HEX_MODE       = 0,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 1
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic                                 load,
   input  logic [4*NUM_DIGITS-1:0]              value,
   input  logic [NUM_DIGITS-1:0]                dp_in,
   input  logic                                 blank_lz,
   output logic [6:0]                           seg,
   output logic                                 dp,
   output logic [NUM_DIGITS-1:0]                an,
   output logic [idx_width(NUM_DIGITS)-1:0]     digit_idx,
   output logic                                 frame_tick
);

   localparam int IW = idx_width(NUM_DIGITS);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [CW-1:0]             cnt;
   logic [4*NUM_DIGITS-1:0]   shadow_val, active_val;
   logic [NUM_DIGITS-1:0]     shadow_dp, active_dp;
   logic [NUM_DIGITS-1:0]     blanked;
   logic [NUM_DIGITS-1:0]     onehot;
   logic [3:0]                cur_nib;
   logic                      cur_dp, cur_blank;
   logic [6:0]                dec_seg;
   logic                      zero_run;
   logic                      last_cnt, last_digit, past_guard, lit;

   assign last_cnt   = (cnt == CW'(CLK_DIV - 1));
   assign last_digit = (digit_idx == IW'(NUM_DIGITS - 1));
   assign onehot     = NUM_DIGITS'(1) << digit_idx;

   generate
      if (BLANK_CYCLES == 0) begin : g_no_guard
         assign past_guard = 1'b1;
      end else begin : g_guard
         assign past_guard = (cnt >= CW'(BLANK_CYCLES));
      end
   endgenerate

   assign lit = en && past_guard && !cur_blank;

   // Shadow captures every load; active only changes at the frame wrap so a frame never tears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         digit_idx  <= '0;
         frame_tick <= 1'b0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         active_val <= '0;
         active_dp  <= '0;
      end else begin
         frame_tick <= 1'b0;
         if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
         end
         if (en) begin
            if (last_cnt) begin
               cnt <= '0;
               if (last_digit) begin
                  digit_idx  <= '0;
                  frame_tick <= 1'b1;
                  active_val <= load ? value : shadow_val;
                  active_dp  <= load ? dp_in : shadow_dp;
               end else begin
                  digit_idx <= digit_idx + 1'b1;
               end
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // Scan from the top digit down; a digit is a leading zero while everything above it is zero.
   always_comb begin
      blanked  = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (active_val[4*i +: 4] == 4'd0);
         if (i > 0)
            blanked[i] = blank_lz && zero_run;
      end
   end

   always_comb begin
      cur_nib   = 4'd0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == IW'(i)) begin
            cur_nib   = active_val[4*i +: 4];
            cur_dp    = active_dp[i];
            cur_blank = blanked[i];
         end
      end
   end

   sevenseg_decode #(
      .HEX_MODE (HEX_MODE)
   ) u_decode (
      .nib (cur_nib),
      .seg (dec_seg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= SEG_INV;
         dp  <= SEG_INV[0];
         an  <= AN_OFF;
      end else begin
         seg <= (cur_blank ? SEG_OFF : dec_seg) ^ SEG_INV;
         dp  <= (cur_dp & ~cur_blank) ^ SEG_INV[0];
         an  <= lit ? (onehot ^ AN_OFF) : AN_OFF;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Bench for sevenseg_scan_mux: table-driven frames through a scoreboard queue plus
// hand-written sequences for reset, tear-free update, hex mode and enable gating.
module tb_sevenseg_scan_mux;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;

   logic [6:0]  seg, seg_h, seg_hn, seg1;
   logic        dp, dp_h, dp_hn, dp1;
   logic [3:0]  an, an_h, an_hn;
   logic [0:0]  an1, idx1;
   logic [1:0]  digit_idx, idx_h, idx_hn;
   logic        frame_tick, tick_h, tick_hn, tick1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sevenseg_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0),
                       .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx),
      .frame_tick(frame_tick));

   sevenseg_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1),
                       .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut_h (
      .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg_h), .dp(dp_h), .an(an_h), .digit_idx(idx_h),
      .frame_tick(tick_h));

   sevenseg_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1),
                       .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_hn (
      .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg_hn), .dp(dp_hn), .an(an_hn), .digit_idx(idx_hn),
      .frame_tick(tick_hn));

   sevenseg_scan_mux #(.NUM_DIGITS(1), .CLK_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0),
                       .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .load(load), .value(value[3:0]), .dp_in(dp_in[0]),
      .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .digit_idx(idx1),
      .frame_tick(tick1));

   typedef struct {
      logic [15:0]     value;
      logic [3:0]      dpv;
      logic            blz;
      logic [3:0][6:0] segs;
      logic [3:0]      dps;
      logic [3:0]      lits;
   } vec_t;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       lit;
   } exp_t;

   vec_t vecs[8];
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the first negedge (possibly the current one) showing frame_tick.
   task automatic wait_tick(input string name);
      int k = 0;
      while (frame_tick !== 1'b1 && k < 64) begin
         step(1);
         k++;
      end
      checks++;
      if (frame_tick !== 1'b1) begin
         errors++;
         $display("FAIL %s: no frame_tick within %0d cycles", name, k);
      end
   endtask

   task automatic wait_an(input string name, input logic [3:0] target);
      int k = 0;
      while (an !== target && k < 64) begin
         step(1);
         k++;
      end
      checks++;
      if (an !== target) begin
         errors++;
         $display("FAIL %s: an=%b never reached %b", name, an, target);
      end
   endtask

   task automatic count_to_tick(input string name, input int lim, output int k);
      k = 0;
      do begin
         step(1);
         k++;
      end while (frame_tick !== 1'b1 && k < lim);
   endtask

   // After the tick at negedge T the state is (digit 0, cnt 0); negedge T+k shows state index k-1.
   task automatic run_vec(input int i);
      exp_t e;
      logic [3:0] one = 4'b0001;
      int d, c;
      value    = vecs[i].value;
      dp_in    = vecs[i].dpv;
      blank_lz = vecs[i].blz;
      load     = 1'b1;
      step(1);
      load     = 1'b0;
      wait_tick($sformatf("vec%0d tick", i));
      for (int k = 0; k < 16; k++) begin
         d     = k / 4;
         c     = k % 4;
         e.lit = vecs[i].lits[d] && (c >= 1);
         e.an  = e.lit ? ~(one << d) : 4'b1111;
         e.seg = vecs[i].segs[d];
         e.dp  = vecs[i].dps[d];
         sb.push_back(e);
      end
      for (int k = 0; sb.size() > 0; k++) begin
         step(1);
         e = sb.pop_front();
         chk($sformatf("vec%0d an k%0d", i, k), 32'(an), 32'(e.an));
         if (e.lit) begin
            chk($sformatf("vec%0d seg k%0d", i, k), 32'(seg), 32'(e.seg));
            chk($sformatf("vec%0d dp k%0d", i, k), 32'(dp), 32'(e.dp));
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      vecs[0] = '{16'h1234, 4'b0100, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0100, 4'b1111};
      vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}, 4'b0000, 4'b0011};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0000, 4'b0001};
      vecs[3] = '{16'h000A, 4'b0000, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b0000000}, 4'b0000, 4'b1111};
      vecs[4] = '{16'h5678, 4'b1001, 1'b0, {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111}, 4'b1001, 4'b1111};
      vecs[5] = '{16'h0900, 4'b1111, 1'b1, {7'b0000000, 7'b1111011, 7'b1111110, 7'b1111110}, 4'b0111, 4'b0111};
      vecs[6] = '{16'h00A0, 4'b0010, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0010, 4'b0011};
      vecs[7] = '{16'h0000, 4'b1000, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b1000, 4'b1111};

      // Reset state
      en = 1'b1;
      step(2);
      chk("reset an", 32'(an), 32'hF);
      chk("reset seg", 32'(seg), 32'h00);
      chk("reset seg active-low", 32'(seg_hn), 32'h7F);
      chk("reset dp", 32'(dp), 32'h0);
      chk("reset tick", 32'(frame_tick), 32'h0);
      chk("reset idx", 32'(digit_idx), 32'h0);
      rst = 1'b0;

      // Frame timing: 16 clocks from release to first wrap, then every 16
      count_to_tick("first tick", 64, k);
      chk("first tick latency", 32'(k), 32'd16);
      count_to_tick("period", 64, k);
      chk("frame period", 32'(k), 32'd16);
      k = 0;
      while (tick1 !== 1'b1 && k < 16) begin step(1); k++; end
      k = 0;
      do begin step(1); k++; end while (tick1 !== 1'b1 && k < 16);
      chk("single digit tick period", 32'(k), 32'd4);
      chk("single digit idx", 32'(idx1), 32'd0);

      run_vec(0);

      // Tear-free: load during digit1 slot leaves the current frame on 1234
      step(4);
      value = 16'h5678; dp_in = 4'b1001; load = 1'b1;
      step(1);
      load = 1'b0;
      wait_an("tear d2", 4'b1011);
      chk("tear d2 seg", 32'(seg), 32'(7'b1101101));
      chk("tear d2 dp", 32'(dp), 32'h1);
      wait_an("tear d3", 4'b0111);
      chk("tear d3 seg", 32'(seg), 32'(7'b0110000));
      step(1);
      wait_tick("tear next frame");
      wait_an("new d0", 4'b1110);
      chk("new d0 seg", 32'(seg), 32'(7'b1111111));
      chk("new d0 dp", 32'(dp), 32'h1);

      // Load coincident with the wrap edge shows from digit 0 of that frame
      step(1);
      wait_tick("align wrap");
      step(15);
      value = 16'h0009; dp_in = 4'b0000; load = 1'b1;
      step(1);
      load = 1'b0;
      chk("wrap load tick", 32'(frame_tick), 32'h1);
      chk("wrap load idx", 32'(digit_idx), 32'h0);
      step(2);
      chk("wrap load an", 32'(an), 32'(4'b1110));
      chk("wrap load seg", 32'(seg), 32'(7'b1111011));

      // Enable gating mid-slot at digit1, cnt1
      step(1);
      wait_tick("align en");
      step(5);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk($sformatf("en off an %0d", i), 32'(an), 32'hF);
         chk($sformatf("en off tick %0d", i), 32'(frame_tick), 32'h0);
         chk($sformatf("en off idx %0d", i), 32'(digit_idx), 32'h1);
      end
      en = 1'b1;
      step(1);
      chk("resume an", 32'(an), 32'(4'b1101));
      chk("resume idx a", 32'(digit_idx), 32'h1);
      step(1);
      chk("resume idx b", 32'(digit_idx), 32'h1);
      step(1);
      chk("resume idx c", 32'(digit_idx), 32'h2);

      for (int i = 1; i < 8; i++) begin
         run_vec(i);
         if (i == 3) begin
            wait_an("hex d0", 4'b1110);
            chk("hex0 seg", 32'(seg), 32'h00);
            chk("hex1 an", 32'(an_h), 32'(4'b1110));
            chk("hex1 seg", 32'(seg_h), 32'(7'b1110111));
            chk("hex1 active-low seg", 32'(seg_hn), 32'(7'b0001000));
            chk("hex1 active-low dp", 32'(dp_hn), 32'h1);
         end
      end

      // Reset mid-slot while digit1 is lit
      step(6);
      chk("pre-reset an lit", 32'(an), 32'(4'b1101));
      rst = 1'b1;
      #1;
      chk("midrst an", 32'(an), 32'hF);
      chk("midrst seg", 32'(seg), 32'h00);
      chk("midrst dp", 32'(dp), 32'h0);
      chk("midrst tick", 32'(frame_tick), 32'h0);
      chk("midrst idx", 32'(digit_idx), 32'h0);
      step(1);
      rst = 1'b0;
      count_to_tick("post-reset tick", 64, k);
      chk("post-reset tick latency", 32'(k), 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
